word_transfer_unit: RTL
=======================

WORD_TRANSFER_UNIT -- requirements
Module: word_transfer_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register word width in bits; multiple of 8, range 16..64; NB = DATA_W/8.
REQ-002 SHALL have parameter ADDR_W, default 16, memory byte-address width.
REQ-003 SHALL have the following ports:
- Clock  in  1  sole clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request strobe; sampled only in IDLE.
- Op  in  1  0 = load (memory to word), 1 = store (word to memory).
- NumBytes  in  $clog2(NB)+1  byte count, 1..NB.
- Endian  in  1  0 = little (byte i at BaseAddr+i is bits [8i+7:8i]), 1 = big.
- Signed  in  1  load extension select (see Configuration).
- BaseAddr  in  ADDR_W  first byte address.
- WrData  in  DATA_W  store source word.
- Mem_Address  out  ADDR_W  byte address to memory.
- Mem_Data  out  8  store byte to memory.
- Mem_WR  out  1  1 = write, 0 = read.
- Mem_CS  out  1  active-low chip select.
- MemOut  in  8  memory read byte; synchronous, valid the cycle after a read access.
- RdData  out  DATA_W  assembled load result.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  one-cycle pulse coincident with Done on a rejected request.

Function
REQ-004 SHALL implement FSM states IDLE, ACCESS, DRAIN, DONE.
REQ-005 In IDLE with Start=1, SHALL latch Op, NumBytes (n), Endian, Signed, BaseAddr and WrData, then enter ACCESS; if n = 0 or n > NB, SHALL enter DONE with Err=1 and perform no memory access.
REQ-006 In ACCESS, SHALL drive Mem_CS=0 for exactly n consecutive cycles, with Mem_Address = BaseAddr+i in access cycle i (0..n-1), modulo 2^ADDR_W.
REQ-007 Store: in access cycle i, SHALL drive Mem_WR=1 and Mem_Data = WrData byte i (little) or byte n-1-i (big); after the last access, SHALL go to DONE (Done in cycle n+1 after acceptance).
REQ-008 Load: SHALL drive Mem_WR=0, capture MemOut on the edge ending the cycle after each access, pass through DRAIN for one cycle, then go to DONE (Done in cycle n+2 after acceptance).
REQ-009 Load placement: SHALL place byte i at lane i (little) or lane n-1-i (big); lanes n..NB-1 SHALL be filled per REQ-016.
REQ-010 RdData SHALL update only on the edge entering DONE after a load and hold its value otherwise; stores SHALL leave RdData unchanged.
REQ-011 DONE SHALL last one cycle and return to IDLE; a Start in that cycle SHALL be ignored.
REQ-012 Start outside IDLE SHALL be ignored; latched operands SHALL not change mid-transfer.
REQ-013 Outside ACCESS, SHALL hold Mem_CS=1, Mem_WR=0, and Mem_Data and Mem_Address at 0.

Reset
REQ-014 Reset=1 on an edge SHALL force IDLE, with RdData=0, Busy=0, Done=0, Err=0, Mem_CS=1, Mem_WR=0 and Mem_Address=0, overriding any transfer in progress. A memory write already issued in that cycle completes; no further access SHALL occur.
REQ-015 Reset SHALL take priority over Start on the same edge.

Configuration
REQ-016 With macro WORD_TRANSFER_SIGN_EXT_EN defined, a load with Signed=1 SHALL fill the unused upper lanes with bit 7 of the most significant loaded byte. Without the macro, and with Signed=0, the unused upper lanes SHALL be zero-filled; without the macro, Signed SHALL be ignored.

Structure
REQ-017 Package word_transfer_pkg SHALL hold the FSM state enum, the OP_LOAD/OP_STORE constants and the ENDIAN_LITTLE/ENDIAN_BIG constants.
REQ-018 Byte-lane placement and extension SHALL be a combinational sub-module word_byte_packer; the FSM, byte counter and capture register SHALL remain in word_transfer_unit.

Verification (DATA_W=32, ADDR_W=16)
REQ-019 Little-endian load, n=4, BaseAddr=0x0010, memory 11 22 33 44 -> RdData=0x44332211, Done in cycle 6 after acceptance, four reads 0x0010..0x0013.
REQ-020 Big-endian store, n=2, WrData=0x0000ABCD, BaseAddr=0x0100 -> writes 0xAB to 0x0100 and 0xCD to 0x0101, Done in cycle 3.
REQ-021 Load, n=1, memory byte 0x80, Signed=1 -> RdData=0xFFFFFF80 with WORD_TRANSFER_SIGN_EXT_EN defined, 0x00000080 without it.
REQ-022 Load, n=4, BaseAddr=0xFFFE -> accesses to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-023 NumBytes=0 and NumBytes=5 -> Done=1 with Err=1 one cycle after Start, no Mem_CS assertion; Start while Busy -> ignored.
REQ-024 Reset asserted in access cycle 2 of a 4-byte load -> next cycle IDLE, Mem_CS=1, RdData=0, no Done pulse.

Source files
------------

// File: rtl/word_transfer_pkg.sv
// word_transfer_pkg: FSM state and operation/endianness encodings
// shared by the word transfer unit and its byte packer.
package word_transfer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic OP_LOAD       = 1'b0;
    localparam logic OP_STORE      = 1'b1;
    localparam logic ENDIAN_LITTLE = 1'b0;
    localparam logic ENDIAN_BIG    = 1'b1;

endpackage

// File: rtl/word_byte_packer.sv
// word_byte_packer: places loaded bytes into word lanes by endianness
// and fills lanes above the transfer length with zero or sign bits.
module word_byte_packer
    import word_transfer_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int CW     = $clog2(NB) + 1
) (
    input  logic [DATA_W-1:0] raw,
    input  logic [CW-1:0]     count,
    input  logic              endian,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] word
);

    int         n;
    int         src;
    int         msb;
    logic [7:0] fill;

    // lane L takes byte L (little) or byte n-1-L (big); upper lanes get fill
    always_comb begin
        n    = (int'(count) > NB) ? NB : int'(count);
        msb  = (endian == ENDIAN_BIG || n == 0) ? 0 : n - 1;
        fill = (sign_ext && raw[8*msb+7]) ? 8'hFF : 8'h00;
        word = '0;
        src  = 0;
        for (int l = 0; l < NB; l++) begin
            if (l < n) begin
                src = (endian == ENDIAN_BIG) ? n - 1 - l : l;
                word[8*l +: 8] = raw[8*src +: 8];
            end else begin
                word[8*l +: 8] = fill;
            end
        end
    end

endmodule

// File: rtl/word_transfer_unit.sv
// word_transfer_unit: byte-serial load/store of a word over an 8-bit memory.
// Define WORD_TRANSFER_SIGN_EXT_EN to enable sign extension of short loads.
module word_transfer_unit
    import word_transfer_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 16,
    localparam int NB     = DATA_W / 8,
    localparam int CW     = $clog2(NB) + 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Op,
    input  logic [CW-1:0]     NumBytes,
    input  logic              Endian,
    input  logic              Signed,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [7:0]        Mem_Data,
    output logic              Mem_WR,
    output logic              Mem_CS,
    input  logic [7:0]        MemOut,
    output logic [DATA_W-1:0] RdData,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    state_t            state;
    logic              lat_op;
    logic              lat_endian;
    logic [CW-1:0]     lat_n;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     ridx;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] cap;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] packed_word;
    logic              pend;
    logic              ext;
    logic              bad;
    logic              last;

`ifdef WORD_TRANSFER_SIGN_EXT_EN
    logic lat_signed;
    assign ext = lat_signed;
`else
    logic unused_signed;
    assign unused_signed = Signed;
    assign ext = 1'b0;
`endif

    function automatic int sidx(input logic e, input logic [CW-1:0] n,
                                input int k);
        return (e == ENDIAN_BIG) ? int'(n) - 1 - k : k;
    endfunction

    function automatic logic [7:0] pick(input logic [DATA_W-1:0] w,
                                        input int idx);
        pick = 8'h00;
        if (idx >= 0 && idx < NB) pick = w[8*idx +: 8];
    endfunction

    assign bad  = (NumBytes == '0) || (int'(NumBytes) > NB);
    assign last = (cnt == lat_n - 1'b1);

    // merge the byte arriving this cycle into the captured bytes
    always_comb begin
        raw = cap;
        if (pend) raw[8*ridx +: 8] = MemOut;
    end

    word_byte_packer #(.DATA_W(DATA_W)) u_packer (
        .raw      (raw),
        .count    (lat_n),
        .endian   (lat_endian),
        .sign_ext (ext),
        .word     (packed_word)
    );

    // transfer sequencer with registered memory-side and status outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            RdData      <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Err         <= 1'b0;
            Mem_CS      <= 1'b1;
            Mem_WR      <= 1'b0;
            Mem_Address <= '0;
            Mem_Data    <= '0;
            cnt         <= '0;
            ridx        <= '0;
            pend        <= 1'b0;
            cap         <= '0;
            lat_op      <= OP_LOAD;
            lat_endian  <= ENDIAN_LITTLE;
            lat_n       <= '0;
            lat_wdata   <= '0;
`ifdef WORD_TRANSFER_SIGN_EXT_EN
            lat_signed  <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            Err  <= 1'b0;
            pend <= (state == ACCESS) && (lat_op == OP_LOAD);
            ridx <= cnt;
            cap  <= raw;
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        lat_op     <= Op;
                        lat_n      <= NumBytes;
                        lat_endian <= Endian;
                        lat_wdata  <= WrData;
`ifdef WORD_TRANSFER_SIGN_EXT_EN
                        lat_signed <= Signed;
`endif
                        cnt  <= '0;
                        Busy <= 1'b1;
                        if (bad) begin
                            state <= DONE;
                            Done  <= 1'b1;
                            Err   <= 1'b1;
                        end else begin
                            state       <= ACCESS;
                            Mem_CS      <= 1'b0;
                            Mem_WR      <= Op;
                            Mem_Address <= BaseAddr;
                            Mem_Data    <= (Op == OP_STORE) ?
                                pick(WrData, sidx(Endian, NumBytes, 0)) :
                                8'h00;
                        end
                    end
                end
                ACCESS: begin
                    if (last) begin
                        Mem_CS      <= 1'b1;
                        Mem_WR      <= 1'b0;
                        Mem_Address <= '0;
                        Mem_Data    <= '0;
                        if (lat_op == OP_STORE) begin
                            state <= DONE;
                            Done  <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        cnt         <= cnt + 1'b1;
                        Mem_Address <= Mem_Address + 1'b1;
                        Mem_Data    <= (lat_op == OP_STORE) ?
                            pick(lat_wdata,
                                 sidx(lat_endian, lat_n, int'(cnt) + 1)) :
                            8'h00;
                    end
                end
                DRAIN: begin
                    state  <= DONE;
                    Done   <= 1'b1;
                    RdData <= packed_word;
                end
                DONE: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
